// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcode/funct
// constants, ALU operation codes and the instruction-class enum produced by mc_decode.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_NOP   = 6'b000000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    typedef enum logic [3:0] {
        C_RALU, C_ORI, C_LUI, C_LOAD, C_STORE,
        C_BEQ, C_J, C_JAL, C_JR, C_NOP, C_ILL
    } mc_class_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: (opCode, Funct) -> instruction class.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_op_code,
    input  logic [5:0] i_funct,
    output mc_class_e  o_class
);

    always_comb begin
        o_class = C_ILL;
        case (i_op_code)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU, FN_SUBU: o_class = C_RALU;
                    FN_JR:            o_class = C_JR;
                    FN_NOP:           o_class = C_NOP;
                    default:          o_class = C_ILL;
                endcase
            end
            OP_ORI:  o_class = C_ORI;
            OP_LUI:  o_class = C_LUI;
            OP_LW:   o_class = C_LOAD;
            OP_SW:   o_class = C_STORE;
            OP_BEQ:  o_class = C_BEQ;
            OP_J:    o_class = C_J;
            OP_JAL:  o_class = C_JAL;
            default: o_class = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with Moore output decode.
// Define MC_CTRL_ILLEGAL_EN to trap unknown encodings in HALT with a sticky illegal flag.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       Branch,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       EXTop,
    output logic       Jump,
    output logic       writeR31,
    output logic       JumpToReg,
    output logic [2:0] ALUop,
    output logic [2:0] state,
    output logic       instr_done
`ifdef MC_CTRL_ILLEGAL_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
`ifdef MC_CTRL_ILLEGAL_EN
    localparam logic [2:0] S_HALT   = ST_HALT;
`endif

    logic [2:0] r_state;
    logic [2:0] w_next;
    mc_class_e  w_class;
    logic       w_multi;

    mc_decode u_decode (
        .i_op_code (opCode),
        .i_funct   (Funct),
        .o_class   (w_class)
    );

    // Classes that continue past EXEC into MEM or WB; everything else retires in EXEC.
    assign w_multi = (w_class == C_RALU) || (w_class == C_ORI) || (w_class == C_LUI) ||
                     (w_class == C_LOAD) || (w_class == C_STORE);

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
`ifdef MC_CTRL_ILLEGAL_EN
            S_DECODE: w_next = (w_class == C_ILL) ? S_HALT : S_EXEC;
            S_HALT:   w_next = S_HALT;
`else
            S_DECODE: w_next = S_EXEC;
`endif
            S_EXEC: begin
                if (w_class == C_LOAD || w_class == C_STORE) w_next = S_MEM;
                else if (w_multi)                            w_next = S_WB;
                else                                         w_next = S_FETCH;
            end
            S_MEM: begin
                if (!mem_ready)              w_next = S_MEM;
                else if (w_class == C_LOAD)  w_next = S_WB;
                else                         w_next = S_FETCH;
            end
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

`ifdef MC_CTRL_ILLEGAL_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (reset)                                         r_illegal <= 1'b0;
        else if (r_state == S_DECODE && w_class == C_ILL)  r_illegal <= 1'b1;
    end

    assign illegal = r_illegal & ~reset;
`endif

    // Every control is forced low during reset so an aborted instruction writes nothing.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        ALUSrc     = 1'b0;
        Branch     = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        EXTop      = 1'b0;
        Jump       = 1'b0;
        writeR31   = 1'b0;
        JumpToReg  = 1'b0;
        ALUop      = ALU_ADD;
        instr_done = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    PCWrite = 1'b1;
                    IRWrite = 1'b1;
                end
                S_EXEC, S_MEM, S_WB: begin
                    // ALU/address controls persist from EXEC through MEM and WB.
                    case (w_class)
                        C_RALU:          ALUop = (Funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                        C_ORI: begin
                            ALUop  = ALU_OR;
                            ALUSrc = 1'b1;
                            EXTop  = 1'b1;
                        end
                        C_LUI: begin
                            ALUop  = ALU_LUI;
                            ALUSrc = 1'b1;
                        end
                        C_LOAD, C_STORE: ALUSrc = 1'b1;
                        C_BEQ:           ALUop = ALU_SUB;
                        default:         ;
                    endcase
                    if (r_state == S_EXEC) begin
                        case (w_class)
                            C_BEQ: Branch = 1'b1;
                            C_J:   Jump = 1'b1;
                            C_JAL: begin
                                Jump     = 1'b1;
                                writeR31 = 1'b1;
                                RegWrite = 1'b1;
                            end
                            C_JR:    JumpToReg = 1'b1;
                            default: ;
                        endcase
                        instr_done = ~w_multi;
                    end else if (r_state == S_MEM) begin
                        MemWrite   = mem_ready && (w_class == C_STORE);
                        instr_done = mem_ready && (w_class == C_STORE);
                    end else begin
                        RegWrite   = 1'b1;
                        RegDst     = (w_class == C_RALU);
                        MemtoReg   = (w_class == C_LOAD);
                        instr_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = reset ? S_FETCH : r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected state and packed control vector.
module tb_mc_ctrl;

    // Packed control vector: {PCWrite,IRWrite,RegWrite,RegDst,ALUSrc,Branch,MemWrite,
    // MemtoReg,EXTop,Jump,writeR31,JumpToReg,ALUop[2:0],instr_done}
    localparam logic [15:0] E_PCW  = 16'h8000;
    localparam logic [15:0] E_IRW  = 16'h4000;
    localparam logic [15:0] E_RW   = 16'h2000;
    localparam logic [15:0] E_RD   = 16'h1000;
    localparam logic [15:0] E_AS   = 16'h0800;
    localparam logic [15:0] E_BR   = 16'h0400;
    localparam logic [15:0] E_MW   = 16'h0200;
    localparam logic [15:0] E_M2R  = 16'h0100;
    localparam logic [15:0] E_EXT  = 16'h0080;
    localparam logic [15:0] E_J    = 16'h0040;
    localparam logic [15:0] E_R31  = 16'h0020;
    localparam logic [15:0] E_JR   = 16'h0010;
    localparam logic [15:0] A_SUB  = 16'h0002;
    localparam logic [15:0] A_OR   = 16'h0004;
    localparam logic [15:0] A_LUI  = 16'h0006;
    localparam logic [15:0] E_DONE = 16'h0001;
    localparam logic [15:0] E_NONE = 16'h0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opCode = 6'b001101;
    logic [5:0] Funct = 6'b000000;
    logic       mem_ready = 1'b1;
    logic       PCWrite, IRWrite, RegWrite, RegDst, ALUSrc, Branch, MemWrite;
    logic       MemtoReg, EXTop, Jump, writeR31, JumpToReg, instr_done;
    logic [2:0] ALUop;
    logic [2:0] state;
`ifdef MC_CTRL_ILLEGAL_EN
    logic       illegal;
`endif
    logic [15:0] w_outs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opCode     (opCode),
        .Funct      (Funct),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .Branch     (Branch),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .EXTop      (EXTop),
        .Jump       (Jump),
        .writeR31   (writeR31),
        .JumpToReg  (JumpToReg),
        .ALUop      (ALUop),
        .state      (state),
        .instr_done (instr_done)
`ifdef MC_CTRL_ILLEGAL_EN
        ,
        .illegal    (illegal)
`endif
    );

    assign w_outs = {PCWrite, IRWrite, RegWrite, RegDst, ALUSrc, Branch, MemWrite,
                     MemtoReg, EXTop, Jump, writeR31, JumpToReg, ALUop, instr_done};

    // Each task starts 1 time unit after a rising edge in a FETCH cycle (or reset)
    // and leaves at the same point of the next instruction's FETCH cycle.
    task automatic test_reset();
        logic [15:0] eo [4];
        logic [2:0]  es [4];
        eo = '{E_PCW | E_IRW, E_NONE, A_OR | E_AS | E_EXT, E_RW | A_OR | E_AS | E_EXT | E_DONE};
        es = '{3'd0, 3'd1, 3'd2, 3'd4};
        reset = 1'b1;
        opCode = 6'b001101;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({state, w_outs} !== {3'd0, E_NONE}) begin
                n_errors++;
                $display("FAIL reset_hold cyc%0d: state=%0d outs=%h, expected state=0 outs=%h",
                         i, state, w_outs, E_NONE);
            end
`ifdef MC_CTRL_ILLEGAL_EN
            n_checks++;
            if (illegal !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_illegal cyc%0d: illegal=%b, expected 0", i, illegal);
            end
`endif
            @(posedge clk); #1;
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({state, w_outs} !== {es[i], eo[i]}) begin
                n_errors++;
                $display("FAIL reset_ori cyc%0d: state=%0d outs=%h, expected state=%0d outs=%h",
                         i, state, w_outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        logic [15:0] eo [7];
        logic [2:0]  es [7];
        logic        mr [7];
        eo = '{E_PCW | E_IRW, E_NONE, E_AS, E_AS, E_AS, E_AS, E_RW | E_M2R | E_AS | E_DONE};
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opCode = 6'b100011;
        Funct = 6'b000101;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            n_checks++;
            if ({state, w_outs} !== {es[i], eo[i]}) begin
                n_errors++;
                $display("FAIL lw_wait cyc%0d: state=%0d outs=%h, expected state=%0d outs=%h",
                         i, state, w_outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        logic [15:0] eo [5];
        logic [2:0]  es [5];
        logic        mr [5];
        eo = '{E_PCW | E_IRW, E_NONE, E_AS, E_AS, E_AS | E_MW | E_DONE};
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        mr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        opCode = 6'b101011;
        Funct = 6'b100001;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            n_checks++;
            if ({state, w_outs} !== {es[i], eo[i]}) begin
                n_errors++;
                $display("FAIL sw_wait cyc%0d: state=%0d outs=%h, expected state=%0d outs=%h",
                         i, state, w_outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // beq, jal, jr, j, nop, addu, subu, lui issued without gaps.
    task automatic test_back_to_back();
        logic [5:0]  op  [8];
        logic [5:0]  fn  [8];
        logic [15:0] exe [8];
        logic [15:0] wb  [8];
        logic        has_wb [8];
        logic [15:0] eo;
        logic [2:0]  es;
        int          n_cyc;
        op  = '{6'b000100, 6'b000011, 6'b000000, 6'b000010, 6'b000000, 6'b000000, 6'b000000, 6'b001111};
        fn  = '{6'b010101, 6'b000000, 6'b001000, 6'b111111, 6'b000000, 6'b100001, 6'b100011, 6'b000000};
        exe = '{A_SUB | E_BR | E_DONE, E_J | E_R31 | E_RW | E_DONE, E_JR | E_DONE, E_J | E_DONE,
                E_DONE, E_NONE, A_SUB, A_LUI | E_AS};
        wb  = '{E_NONE, E_NONE, E_NONE, E_NONE, E_NONE, E_RW | E_RD | E_DONE,
                E_RW | E_RD | A_SUB | E_DONE, E_RW | A_LUI | E_AS | E_DONE};
        has_wb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            opCode = op[k];
            Funct = fn[k];
            n_cyc = has_wb[k] ? 4 : 3;
            for (int c = 0; c < n_cyc; c++) begin
                mem_ready = 1'($urandom_range(0, 1));
                case (c)
                    0:       begin es = 3'd0; eo = E_PCW | E_IRW; end
                    1:       begin es = 3'd1; eo = E_NONE; end
                    2:       begin es = 3'd2; eo = exe[k]; end
                    default: begin es = 3'd4; eo = wb[k]; end
                endcase
                @(negedge clk);
                n_checks++;
                if ({state, w_outs} !== {es, eo}) begin
                    n_errors++;
                    $display("FAIL b2b instr%0d cyc%0d: state=%0d outs=%h, expected state=%0d outs=%h",
                             k, c, state, w_outs, es, eo);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [15:0] eo [10];
        logic [2:0]  es [10];
        logic        mr [10];
        logic        rs [10];
        eo = '{E_PCW | E_IRW, E_NONE, E_AS, E_AS, E_AS, E_NONE, E_PCW | E_IRW, E_NONE, E_AS,
               E_AS | E_MW | E_DONE};
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
        mr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opCode = 6'b101011;
        Funct = 6'b000000;
        for (int i = 0; i < 10; i++) begin
            mem_ready = mr[i];
            reset = rs[i];
            @(negedge clk);
            n_checks++;
            if ({state, w_outs} !== {es[i], eo[i]}) begin
                n_errors++;
                $display("FAIL reset_mid_mem cyc%0d: state=%0d outs=%h, expected state=%0d outs=%h",
                         i, state, w_outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        opCode = 6'b111111;
        Funct = 6'b000000;
        mem_ready = 1'b1;
`ifdef MC_CTRL_ILLEGAL_EN
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (i == 0) begin
                if ({state, w_outs, illegal} !== {3'd0, E_PCW | E_IRW, 1'b0}) begin
                    n_errors++;
                    $display("FAIL illegal_fetch: state=%0d outs=%h illegal=%b, expected state=0 outs=%h illegal=0",
                             state, w_outs, illegal, E_PCW | E_IRW);
                end
            end else if (i == 1) begin
                if ({state, w_outs, illegal} !== {3'd1, E_NONE, 1'b0}) begin
                    n_errors++;
                    $display("FAIL illegal_decode: state=%0d outs=%h illegal=%b, expected state=1 outs=0000 illegal=0",
                             state, w_outs, illegal);
                end
            end else begin
                if ({state, w_outs, illegal} !== {3'd5, E_NONE, 1'b1}) begin
                    n_errors++;
                    $display("FAIL illegal_halt cyc%0d: state=%0d outs=%h illegal=%b, expected state=5 outs=0000 illegal=1",
                             i, state, w_outs, illegal);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        opCode = 6'b000000;
        @(negedge clk);
        n_checks++;
        if ({state, w_outs, illegal} !== {3'd0, E_PCW | E_IRW, 1'b0}) begin
            n_errors++;
            $display("FAIL illegal_clear: state=%0d outs=%h illegal=%b, expected state=0 outs=%h illegal=0",
                     state, w_outs, illegal, E_PCW | E_IRW);
        end
        @(posedge clk); #1;
`else
        begin
            logic [15:0] eo [4];
            logic [2:0]  es [4];
            eo = '{E_PCW | E_IRW, E_NONE, E_DONE, E_PCW | E_IRW};
            es = '{3'd0, 3'd1, 3'd2, 3'd0};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                n_checks++;
                if ({state, w_outs} !== {es[i], eo[i]}) begin
                    n_errors++;
                    $display("FAIL illegal_as_nop cyc%0d: state=%0d outs=%h, expected state=%0d outs=%h",
                             i, state, w_outs, es[i], eo[i]);
                end
                @(posedge clk); #1;
            end
        end
`endif
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_sw();
        test_back_to_back();
        test_reset_mid_mem();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS core. It sequences one instruction through FETCH, DECODE, EXEC, MEM and WB states, so the datapath's shared ALU and memory port run over several cycles instead of one. It sits beside the datapath, takes `opCode`/`Funct` from the instruction register and drives every datapath control input plus the PC and IR write enables.

## Interface
Parameters:
- none; encodings are fixed in `mc_pkg`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `opCode` in 6: IR[31:26]; stable from DECODE onward.
- `Funct` in 6: IR[5:0].
- `mem_ready` in 1: data memory completes the access this cycle; only sampled in MEM.
- `PCWrite` out 1: PC loads PC+4 this cycle.
- `IRWrite` out 1: IR loads the fetched word this cycle.
- `RegWrite`, `RegDst`, `ALUSrc`, `Branch`, `MemWrite`, `MemtoReg`, `EXTop`, `Jump`, `writeR31`, `JumpToReg` out 1 each: datapath controls; meanings unchanged.
- `ALUop` out 3: 000 ADD, 001 SUB, 010 OR, 011 LUI (imm<<16); other codes are never driven.
- `state` out 3: current state code, for debug.
- `instr_done` out 1: one-cycle pulse on the final cycle of every instruction.
- `illegal` out 1: sticky flag; present only with `MC_CTRL_ILLEGAL_EN`.

## Operation
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Outputs are Moore decodes of (`state`, `opCode`, `Funct`).
- Every output not listed as asserted for a state is 0 in that state.
- FETCH: assert `IRWrite` and `PCWrite`, then go to DECODE.
- DECODE: decode only, no writes, then go to EXEC. Unknown opcode: see Configuration.
- EXEC, by class:
  - addu (funct 100001), subu (100011): `ALUop` ADD or SUB, `ALUSrc`=0. Go to WB.
  - ori (001101): `ALUop` OR, `ALUSrc`=1, `EXTop`=1 (zero-extend). Go to WB.
  - lui (001111): `ALUop` LUI, `ALUSrc`=1. Go to WB.
  - lw (100011), sw (101011): `ALUop` ADD, `ALUSrc`=1, `EXTop`=0. Go to MEM.
  - beq (000100): `ALUop` SUB, `Branch`=1. Go to FETCH and pulse `instr_done`.
  - j (000010): `Jump`=1. Go to FETCH and pulse `instr_done`.
  - jal (000011): `Jump`, `writeR31`, `RegWrite`. Go to FETCH and pulse `instr_done`.
  - jr (R, funct 001000): `JumpToReg`=1. Go to FETCH and pulse `instr_done`.
  - nop (R, funct 000000): no controls. Go to FETCH and pulse `instr_done`.
- MEM:
  - Hold the EXEC address controls.
  - sw: assert `MemWrite` only in the cycle where `mem_ready`=1.
  - While `mem_ready`=0, stay in MEM with all write enables low.
  - Exit on `mem_ready`=1: sw goes to FETCH and pulses `instr_done`; lw goes to WB.
- WB:
  - Assert `RegWrite` and hold the EXEC ALU controls.
  - R-type: `RegDst`=1. lw: `MemtoReg`=1.
  - Go to FETCH and pulse `instr_done`.

## Timing
- Reset:
  - While `reset`=1, every output is 0 and `state` is held at FETCH, with FETCH's output decode suppressed.
  - The first FETCH with `IRWrite`=1 is the cycle after `reset` falls.
- Reset asserted in any state aborts the instruction.
  - Nothing is written in the reset cycle.
  - `illegal` clears.
- Latency in cycles, FETCH to `instr_done` inclusive:
  - R-type ALU, ori, lui: 4.
  - sw: 4 + wait cycles.
  - lw: 5 + wait cycles.
  - beq, j, jal, jr, nop: 3.
- `instr_done` is asserted exactly once per instruction. The next cycle is always FETCH, except after reset.
- `RegWrite` and `MemWrite` are each high for at most one cycle per instruction.
- `mem_ready` held high continuously gives zero wait states. `mem_ready` outside MEM is ignored.

## Configuration
- `MC_CTRL_ILLEGAL_EN` defined:
  - An unrecognised opcode or R-type funct in DECODE goes to HALT and sets `illegal`=1.
  - HALT holds with all controls 0 and no `instr_done` until `reset`.
- Not defined:
  - Unknown encodings execute as nop: DECODE→EXEC→FETCH with `instr_done`.
  - The `illegal` port and HALT state are absent.

## Structure
- Package `mc_pkg` holds:
  - state enum;
  - opcode constants (RTYPE, ORI, LW, SW, BEQ, LUI, J, JAL);
  - funct constants (ADDU, SUBU, JR, NOP);
  - ALUop constants;
  - an instruction-class enum (RALU, ORI, LUI, LOAD, STORE, BEQ, J, JAL, JR, NOP, ILL).
- Sub-module `mc_decode`: combinational (`opCode`, `Funct`) → class. `mc_ctrl` keeps the FSM and per-state output decode.

## Test plan
- Reset held 3 cycles, then released with opCode=001101 and `mem_ready`=1:
  - all outputs 0 during reset;
  - `IRWrite`=`PCWrite`=1 in cycle 1 after release;
  - `instr_done` in cycle 4 with `RegWrite`=1 and `EXTop`=1.
- lw (100011) with `mem_ready` low for 2 MEM cycles:
  - state sequence 0,1,2,3,3,3,4;
  - `RegWrite`=1 and `MemtoReg`=1 only in the WB cycle;
  - total 7 cycles.
- sw (101011) with `mem_ready`=0 then 1:
  - `MemWrite` high exactly one cycle, coincident with `mem_ready`;
  - `RegWrite` never high;
  - `instr_done` in that cycle.
- beq, jal, jr back-to-back:
  - each takes 3 cycles;
  - EXEC asserts `Branch`+SUB, then `Jump`+`writeR31`+`RegWrite`, then `JumpToReg` respectively.
- Reset asserted during MEM of a stalled sw: `MemWrite` stays 0, and the next cycle after release is FETCH.
- opCode=111111:
  - with `MC_CTRL_ILLEGAL_EN`: HALT (state 5) and `illegal`=1 held for 10 cycles;
  - without it: `instr_done` at cycle 3 with no writes.
